// File: rtl/tone_scheduler_if.sv
// rtl/tone_scheduler_if.sv - control and tone-output bundle for tone_scheduler
//
// Signals:
//   tick        note time-base pulse (to scheduler)
//   start       request melody playback (to scheduler)
//   stop        abort melody and any pending resume (to scheduler)
//   click_req   request key click (to scheduler)
//   half_period tone generator compare value, 0 when silent (from scheduler)
//   tone_en     tone generator enable (from scheduler)
//   busy        melody playing or paused under a click (from scheduler)
//   done        one-cycle pulse on natural melody completion (from scheduler)
// Modports: master drives the requests, slave is the scheduler.
interface tone_scheduler_if;
  logic        tick;
  logic        start;
  logic        stop;
  logic        click_req;
  logic [10:0] half_period;
  logic        tone_en;
  logic        busy;
  logic        done;

  modport master (
    output tick, start, stop, click_req,
    input  half_period, tone_en, busy, done
  );

  modport slave (
    input  tick, start, stop, click_req,
    output half_period, tone_en, busy, done
  );
endinterface

// File: rtl/tone_scheduler.sv
// rtl/tone_scheduler.sv - melody sequencer and key-click arbiter for the buzzer tone generator
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  tone_scheduler_if.slave: tick/start/stop/click_req in,
//        half_period/tone_en/busy/done out (all outputs registered)
// Parameters:
//   CLICK_HP      half-period value played during a key click
//   CLICK_CYCLES  click duration in clk cycles (>= 2)
module tone_scheduler #(
  parameter int CLICK_HP     = 638,
  parameter int CLICK_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              rst,
  tone_scheduler_if.slave   bus
);

  localparam int CW = (CLICK_CYCLES > 2) ? $clog2(CLICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(CLICK_CYCLES - 1);
  localparam logic [10:0]   CLICK_VAL = 11'(CLICK_HP);
  localparam logic [3:0]    LAST_STEP = 4'd11;

  typedef enum logic [1:0] {IDLE, MELODY, CLICK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic          paused_q, paused_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_d;

  logic [10:0]   half_period_q, half_period_d;
  logic          tone_en_q, tone_en_d;
  logic          busy_q, busy_d;
  logic          done_q;

  function automatic logic [10:0] melody_hp(input logic [3:0] s);
    case (s)
      4'd0, 4'd1:         melody_hp = 11'd1517;
      4'd2, 4'd8:         melody_hp = 11'd1275;
      4'd3, 4'd4, 4'd5:   melody_hp = 11'd851;
      4'd6, 4'd7:         melody_hp = 11'd956;
      default:            melody_hp = 11'd1432;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    paused_d = paused_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.click_req) begin
          // A start arriving with the click is queued behind it.
          state_d  = CLICK;
          cnt_d    = CNT_LOAD;
          paused_d = bus.start;
          step_d   = 4'd0;
        end else if (bus.start) begin
          state_d = MELODY;
          step_d  = 4'd0;
        end
      end

      MELODY: begin
        // Priority: stop, then click (swallows a coincident tick), then tick.
        if (bus.stop) begin
          state_d = IDLE;
          step_d  = 4'd0;
        end else if (bus.click_req) begin
          state_d  = CLICK;
          cnt_d    = CNT_LOAD;
          paused_d = 1'b1;
        end else if (bus.tick) begin
          if (step_q == LAST_STEP) begin
            state_d = IDLE;
            step_d  = 4'd0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end

      CLICK: begin
        if (bus.stop) begin
          paused_d = 1'b0;
          step_d   = 4'd0;
        end else if (bus.start && !paused_q) begin
          paused_d = 1'b1;
          step_d   = 4'd0;
        end

        // Ticks are ignored here so the paused note is stretched, not cut.
        if (bus.click_req) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          if (paused_d) begin
            state_d  = MELODY;
            paused_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        step_d   = 4'd0;
        paused_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from next state so they register on the same edge.
  always_comb begin
    tone_en_d     = (state_d != IDLE);
    busy_d        = (state_d == MELODY) || paused_d;
    half_period_d = 11'd0;
    if (state_d == CLICK) begin
      half_period_d = CLICK_VAL;
    end else if (state_d == MELODY) begin
      half_period_d = melody_hp(step_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      step_q        <= 4'd0;
      paused_q      <= 1'b0;
      cnt_q         <= '0;
      half_period_q <= 11'd0;
      tone_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      paused_q      <= paused_d;
      cnt_q         <= cnt_d;
      half_period_q <= half_period_d;
      tone_en_q     <= tone_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.half_period = half_period_q;
  assign bus.tone_en     = tone_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
